carbon_mcs_sync_gen: RTL

//  Generates the AD9361 multi-chip-sync (MCS) pulse on mcs_sync from the PS EMIO request bit 51 (gpio_sync).

---
 rtl/carbon_mcs_sync_gen_pkg.sv | 22 ++
 rtl/carbon_cdc_sync.sv | 20 ++
 rtl/carbon_mcs_sync_gen.sv | 112 +++++++++++
 3 files changed

// File: rtl/carbon_mcs_sync_gen_pkg.sv
// rtl/carbon_mcs_sync_gen_pkg.sv - shared types and constants for the MCS pulse generator
package carbon_mcs_sync_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_PULSE = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  // EMIO bit positions used by system_top when splitting gpio_o/gpio_i
  localparam int GPIO_SYNC_BIT    = 51;
  localparam int GPIO_BUSY_BIT    = 46;
  localparam int GPIO_OVERRUN_BIT = 47;
  localparam int GPIO_COUNT_BASE  = 59;
  localparam int GPIO_COUNT_BITS  = 6;

  function automatic logic [7:0] load_cnt(input int cycles);
    return 8'(cycles - 1);
  endfunction

endpackage

// File: rtl/carbon_cdc_sync.sv
// rtl/carbon_cdc_sync.sv - N-stage reset-to-0 single-bit synchronizer
module carbon_cdc_sync #(
  parameter int STAGES = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_chain;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_chain <= '0;
    else       r_chain <= {r_chain[STAGES-2:0], i_d};
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/carbon_mcs_sync_gen.sv
// rtl/carbon_mcs_sync_gen.sv - AD9361 multi-chip-sync pulse generator
// Synchronizes the EMIO request, then delays, shapes and rate-limits the mcs_sync pulse.
module carbon_mcs_sync_gen
  import carbon_mcs_sync_gen_pkg::*;
#(
  parameter int SYNC_STAGES    = 3,
  parameter int DELAY_CYCLES   = 16,
  parameter int PULSE_CYCLES   = 4,
  parameter int HOLDOFF_CYCLES = 64,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sync_req,
  input  logic                 overrun_clr,
  output logic                 mcs_sync,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] sync_count,
  output logic                 overrun
);

  localparam logic [7:0] LD_DELAY = load_cnt(DELAY_CYCLES);
  localparam logic [7:0] LD_PULSE = load_cnt(PULSE_CYCLES);
  localparam logic [7:0] LD_HOLD  = load_cnt(HOLDOFF_CYCLES);

  state_t               r_state, w_state_nxt;
  logic [7:0]           r_cnt, w_cnt_nxt;
  logic                 r_pending, w_pending_nxt;
  logic                 r_sync_d, r_mcs, r_overrun;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 w_sync_s, w_rise, w_ovr_set, w_count_inc;

  carbon_cdc_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (sync_req),
    .o_q   (w_sync_s)
  );

  assign w_rise = w_sync_s & ~r_sync_d;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pending_nxt = r_pending;
    w_ovr_set     = 1'b0;
    w_count_inc   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise || r_pending) begin
          w_state_nxt   = ST_ARM;
          w_cnt_nxt     = LD_DELAY;
          // a fresh rise on the cycle a queued request is consumed becomes the new queued one
          w_pending_nxt = w_rise & r_pending;
        end
      end
      ST_ARM: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = ST_PULSE;
          w_cnt_nxt   = LD_PULSE;
          w_count_inc = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      ST_PULSE: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = LD_HOLD;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      ST_HOLD: begin
        if (r_cnt == 8'd0) w_state_nxt = ST_IDLE;
        else               w_cnt_nxt   = r_cnt - 8'd1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (r_state != ST_IDLE && w_rise) begin
      if (r_pending) w_ovr_set     = 1'b1;
      else           w_pending_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 8'd0;
      r_pending <= 1'b0;
      r_sync_d  <= 1'b0;
      r_mcs     <= 1'b0;
      r_overrun <= 1'b0;
      r_count   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pending <= w_pending_nxt;
      r_sync_d  <= w_sync_s;
      r_mcs     <= (w_state_nxt == ST_PULSE);
      if (w_ovr_set)        r_overrun <= 1'b1;
      else if (overrun_clr) r_overrun <= 1'b0;
      if (w_count_inc) r_count <= r_count + CNT_WIDTH'(1);
    end
  end

  assign mcs_sync   = r_mcs;
  assign busy       = (r_state != ST_IDLE) | r_pending;
  assign sync_count = r_count;
  assign overrun    = r_overrun;

endmodule
